// File: rtl/sample_iter_if.sv
// Triangle-in / sample-out bundle between the bbox stage, sample_iter_ctrl and the sample tester.
// Performance counter signals exist only when SAMPLE_ITER_PERF_EN is defined.
interface sample_iter_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_in;
    logic signed [1:0][1:0][SIGFIG-1:0]            box_in;
    logic        [3:0]                             subSample_in;
    logic                                          validTri_in;
    logic                                          ready_out;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_out;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_out;
    logic signed [1:0][SIGFIG-1:0]                 sample_out;
    logic                                          validSamp_out;
    logic                                          stall_in;
`ifdef SAMPLE_ITER_PERF_EN
    logic        [31:0]                            sampCnt_out;
    logic        [15:0]                            triCnt_out;
`endif

    modport master (
        output tri_in, color_in, box_in, subSample_in, validTri_in, stall_in,
        input  ready_out, tri_out, color_out, sample_out, validSamp_out
`ifdef SAMPLE_ITER_PERF_EN
        , input sampCnt_out, triCnt_out
`endif
    );

    modport slave (
        input  tri_in, color_in, box_in, subSample_in, validTri_in, stall_in,
        output ready_out, tri_out, color_out, sample_out, validSamp_out
`ifdef SAMPLE_ITER_PERF_EN
        , output sampCnt_out, triCnt_out
`endif
    );
endinterface

// File: rtl/sample_iter_ctrl.sv
// Walks every MSAA sample inside a triangle's bounding box in raster order, one per cycle.
// Define SAMPLE_ITER_PERF_EN to add saturating sample/triangle counters.
module sample_iter_ctrl #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic          clk,
    input  logic          rst,
    sample_iter_if.slave  bus
);
    localparam int EW = SIGFIG + 1;

    typedef enum logic {IDLE, TEST} state_t;

    state_t state, state_next;

    logic signed [SIGFIG-1:0]                      ll_x_p1, ll_y_p1, ur_x_p1, ur_y_p1;
    logic signed [SIGFIG-1:0]                      x_p1, y_p1;
    logic        [SIGFIG-1:0]                      step_p1;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_p1;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_p1;

    logic signed [EW-1:0] nx, ny, ur_x_ext, ur_y_ext, step_ext;
    logic                 accept, degenerate, x_wrap, last, advance;

    // Non-one-hot modes fall back to one sample per pixel.
    function automatic logic [SIGFIG-1:0] decode_step(input logic [3:0] mode);
        int k;
        case (mode)
            4'b0100: k = 1;
            4'b0010: k = 2;
            4'b0001: k = 3;
            default: k = 0;
        endcase
        return {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - k);
    endfunction

    assign accept     = bus.validTri_in && (state == IDLE);
    assign degenerate = ($signed(bus.box_in[1][0]) < $signed(bus.box_in[0][0])) ||
                        ($signed(bus.box_in[1][1]) < $signed(bus.box_in[0][1]));
    assign advance    = (state == TEST) && !bus.stall_in;

    // One extra bit keeps x+step from wrapping past the positive limit.
    assign step_ext = $signed({1'b0, step_p1});
    assign ur_x_ext = $signed({ur_x_p1[SIGFIG-1], ur_x_p1});
    assign ur_y_ext = $signed({ur_y_p1[SIGFIG-1], ur_y_p1});
    assign nx       = $signed({x_p1[SIGFIG-1], x_p1}) + step_ext;
    assign ny       = $signed({y_p1[SIGFIG-1], y_p1}) + step_ext;
    assign x_wrap   = nx > ur_x_ext;
    assign last     = x_wrap && (ny > ur_y_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !degenerate) state_next = TEST;
            TEST:    if (advance && last)       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: latched triangle and the sample walker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ll_x_p1  <= '0;
            ll_y_p1  <= '0;
            ur_x_p1  <= '0;
            ur_y_p1  <= '0;
            x_p1     <= '0;
            y_p1     <= '0;
            step_p1  <= '0;
            tri_p1   <= '0;
            color_p1 <= '0;
        end else if (accept) begin
            ll_x_p1  <= bus.box_in[0][0];
            ll_y_p1  <= bus.box_in[0][1];
            ur_x_p1  <= bus.box_in[1][0];
            ur_y_p1  <= bus.box_in[1][1];
            x_p1     <= bus.box_in[0][0];
            y_p1     <= bus.box_in[0][1];
            step_p1  <= decode_step(bus.subSample_in);
            tri_p1   <= bus.tri_in;
            color_p1 <= bus.color_in;
        end else if (advance && !last) begin
            if (x_wrap) begin
                x_p1 <= ll_x_p1;
                y_p1 <= ny[SIGFIG-1:0];
            end else begin
                x_p1 <= nx[SIGFIG-1:0];
            end
        end
    end

    assign bus.ready_out     = (state == IDLE);
    assign bus.validSamp_out = (state == TEST);
    assign bus.tri_out       = tri_p1;
    assign bus.color_out     = color_p1;
    assign bus.sample_out    = {y_p1, x_p1};

`ifdef SAMPLE_ITER_PERF_EN
    logic [31:0] samp_cnt_p1;
    logic [15:0] tri_cnt_p1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt_p1 <= '0;
            tri_cnt_p1  <= '0;
        end else begin
            if (advance)                samp_cnt_p1 <= sat_inc32(samp_cnt_p1);
            if (accept && !degenerate)  tri_cnt_p1  <= sat_inc16(tri_cnt_p1);
        end
    end

    assign bus.sampCnt_out = samp_cnt_p1;
    assign bus.triCnt_out  = tri_cnt_p1;
`endif
endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Bench for sample_iter_ctrl: raster-order sample model plus directed scenarios.
module tb_sample_iter_ctrl;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_iter_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus();

    sample_iter_ctrl #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint       x;
        longint       y;
        logic [255:0] tri_v;
        logic [255:0] col_v;
    } samp_t;

    samp_t  exp_q[$];
    longint shown_x[$], shown_y[$];
    longint took_x[$],  took_y[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic check_bits(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic longint model_step(input logic [3:0] mode);
        case (mode)
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Every sample the triangle must produce, in raster order.
    task automatic push_model(input longint llx, input longint lly, input longint urx,
                              input longint ury, input logic [3:0] mode);
        samp_t  s;
        longint st = model_step(mode);
        s.tri_v = 256'(bus.tri_in);
        s.col_v = 256'(bus.color_in);
        for (longint y = lly; y <= ury; y += st)
            for (longint x = llx; x <= urx; x += st) begin
                s.x = x;
                s.y = y;
                exp_q.push_back(s);
            end
    endtask

    task automatic clear_logs();
        shown_x.delete(); shown_y.delete();
        took_x.delete();  took_y.delete();
    endtask

    task automatic set_tri(input longint llx, input longint lly, input longint urx,
                           input longint ury, input logic [3:0] mode);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                bus.tri_in[v][a] = SIGFIG'($urandom());
        for (int c = 0; c < COLORS; c++)
            bus.color_in[c] = SIGFIG'($urandom());
        bus.box_in[0][0] = llx[SIGFIG-1:0];
        bus.box_in[0][1] = lly[SIGFIG-1:0];
        bus.box_in[1][0] = urx[SIGFIG-1:0];
        bus.box_in[1][1] = ury[SIGFIG-1:0];
        bus.subSample_in = mode;
    endtask

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic send(input longint llx, input longint lly, input longint urx,
                        input longint ury, input logic [3:0] mode);
        int g = 0;
        set_tri(llx, lly, urx, ury, mode);
        bus.validTri_in = 1'b1;
        while (!bus.ready_out && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) check("send_timeout", g, 0);
        @(posedge clk);
        push_model(llx, lly, urx, ury, mode);
        #1;
        bus.validTri_in = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd_stall);
        int g = 0;
        while ((exp_q.size() != 0 || bus.validSamp_out) && g < 2000) begin
            if (rnd_stall) bus.stall_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            g++;
        end
        bus.stall_in = 1'b0;
        if (g >= 2000) check("idle_timeout", g, 0);
    endtask

    // Per-cycle comparison against the model queue.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", longint'(bus.validSamp_out), longint'(exp_q.size() != 0));
            check("ready", longint'(bus.ready_out), longint'(exp_q.size() == 0));
            if (bus.validSamp_out && exp_q.size() != 0) begin
                check("sample_x", $signed(bus.sample_out[0]), exp_q[0].x);
                check("sample_y", $signed(bus.sample_out[1]), exp_q[0].y);
                check_bits("tri_out", 256'(bus.tri_out), exp_q[0].tri_v);
                check_bits("color_out", 256'(bus.color_out), exp_q[0].col_v);
                shown_x.push_back($signed(bus.sample_out[0]));
                shown_y.push_back($signed(bus.sample_out[1]));
                if (!bus.stall_in) begin
                    took_x.push_back($signed(bus.sample_out[0]));
                    took_y.push_back($signed(bus.sample_out[1]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    longint ex1_x[6] = '{0, 1024, 2048, 0, 1024, 2048};
    longint ex1_y[6] = '{0, 0, 0, 1024, 1024, 1024};
    longint ex2_x[4] = '{512, 1024, 512, 1024};
    longint ex2_y[4] = '{512, 512, 1024, 1024};
    int     held;
`ifdef SAMPLE_ITER_PERF_EN
    longint tri_before;
`endif

    initial begin
        rst = 1'b1;
        bus.tri_in = '0; bus.color_in = '0; bus.box_in = '0;
        bus.subSample_in = 4'b1000; bus.validTri_in = 1'b0; bus.stall_in = 1'b0;
        #12;
        check("rst_ready", longint'(bus.ready_out), 1);
        check("rst_valid", longint'(bus.validSamp_out), 0);
        check("rst_sample", longint'(bus.sample_out), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1x box, six samples, ready again on the 7th cycle
        clear_logs();
        send(0, 0, 2048, 1024, 4'b1000);
        repeat (5) @(posedge clk);
        #1 check("t1_ready_c6", longint'(bus.ready_out), 0);
        @(posedge clk);
        #1 check("t1_ready_c7", longint'(bus.ready_out), 1);
        wait_idle(1'b0);
        check("t1_count", took_x.size(), 6);
        for (int i = 0; i < 6 && i < took_x.size(); i++) begin
            check("t1_x", took_x[i], ex1_x[i]);
            check("t1_y", took_y[i], ex1_y[i]);
        end

        // 4x mode
        clear_logs();
        send(512, 512, 1024, 1024, 4'b0100);
        wait_idle(1'b0);
        check("t2_count", took_x.size(), 4);
        for (int i = 0; i < 4 && i < took_x.size(); i++) begin
            check("t2_x", took_x[i], ex2_x[i]);
            check("t2_y", took_y[i], ex2_y[i]);
        end

        // Stall while (1024,0) is shown
        clear_logs();
        send(0, 0, 2048, 1024, 4'b1000);
        @(posedge clk); #1;
        bus.stall_in = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.stall_in = 1'b0;
        wait_idle(1'b0);
        held = 0;
        for (int i = 0; i < shown_x.size(); i++)
            if (shown_x[i] == 1024 && shown_y[i] == 0) held++;
        check("t3_held", held, 4);
        check("t3_unique", took_x.size(), 6);
        if (took_x.size() > 2) check("t3_after_x", took_x[2], 2048);

        // Degenerate box
        clear_logs();
`ifdef SAMPLE_ITER_PERF_EN
        tri_before = bus.triCnt_out;
`endif
        send(2048, 0, 1024, 1024, 4'b1000);
        repeat (3) begin @(posedge clk); #1; end
        check("t4_valid", longint'(bus.validSamp_out), 0);
        check("t4_ready", longint'(bus.ready_out), 1);
        check("t4_count", took_x.size(), 0);
`ifdef SAMPLE_ITER_PERF_EN
        check("t4_tricnt", bus.triCnt_out, tri_before);
`endif

        // Async reset while the third sample is shown
        send(0, 0, 2048, 1024, 4'b1000);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_valid", longint'(bus.validSamp_out), 0);
        check("t5_ready", longint'(bus.ready_out), 1);
        check("t5_sample", longint'(bus.sample_out), 0);
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        send(-1024, -1024, 0, 0, 4'b1000);
        wait_idle(1'b0);
        check("t5_count", took_x.size(), 4);
        if (took_x.size() > 0) begin
            check("t5_first_x", took_x[0], -1024);
            check("t5_first_y", took_y[0], -1024);
        end

        // Back-to-back single-sample boxes with validTri_in held high
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        set_tri(0, 0, 0, 0, 4'b1000);
        bus.validTri_in = 1'b1;
        @(posedge clk);
        push_model(0, 0, 0, 0, 4'b1000);
        #1 set_tri(4096, 4096, 4096, 4096, 4'b1000);
        check("t6_busy", longint'(bus.ready_out), 0);
        @(posedge clk); #1;
        check("t6_bubble_valid", longint'(bus.validSamp_out), 0);
        check("t6_bubble_ready", longint'(bus.ready_out), 1);
        @(posedge clk);
        push_model(4096, 4096, 4096, 4096, 4'b1000);
        #1 bus.validTri_in = 1'b0;
        check("t6_second_valid", longint'(bus.validSamp_out), 1);
        wait_idle(1'b0);
        check("t6_count", took_x.size(), 2);
        if (took_x.size() > 1) check("t6_second_x", took_x[1], 4096);
`ifdef SAMPLE_ITER_PERF_EN
        check("t6_sampcnt", bus.sampCnt_out, 2);
        check("t6_tricnt", bus.triCnt_out, 2);
`endif

        // 16x, negative and unaligned corners
        clear_logs();
        send(-300, 100, 700, 900, 4'b0010);
        wait_idle(1'b0);
        check("t7_count", took_x.size(), 16);
        if (took_x.size() == 16) begin
            check("t7_last_x", took_x[15], 468);
            check("t7_last_y", took_y[15], 868);
        end

        // Non-one-hot mode decodes as 1 sample/px
        clear_logs();
        send(0, 0, 1023, 1023, 4'b1100);
        wait_idle(1'b0);
        check("t8_count", took_x.size(), 1);

        // 64x with random stalls
        clear_logs();
        send(0, 0, 256, 128, 4'b0001);
        wait_idle(1'b1);
        check("t9_count", took_x.size(), 6);
        if (took_x.size() == 6) begin
            check("t9_last_x", took_x[5], 256);
            check("t9_last_y", took_y[5], 128);
        end

        // x + step beyond the positive limit must not wrap
        clear_logs();
        send(8388000, -5, 8388607, -5, 4'b1000);
        wait_idle(1'b0);
        check("t10_count", took_x.size(), 1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/sample_iter_ctrl.md
Name: sample_iter_ctrl

Overview:
Per-triangle sample scheduler that sits directly upstream of the sample test stage in the raster pipeline.
- Accepts one triangle, its bounding box and its MSAA mode from the bbox stage.
- Walks every sample location inside the box in raster order, one sample per cycle.
- Presents triangle, colour and sample location to the sample tester with a valid flag.
- Honours downstream backpressure and holds off upstream while a triangle is being iterated.

Parameters:
SIGFIG, 24, bits in colour and position (signed fixed point for positions)
RADIX, 10, fraction bits in position
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, colour channels

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
tri_in  in  SIGFIG x VERTS x AXIS (signed)  triangle vertices
color_in  in  SIGFIG x COLORS (unsigned)  triangle colour
box_in  in  SIGFIG x 2 x 2 (signed)  [0]=lower-left (x,y), [1]=upper-right (x,y)
subSample_in  in  4  one-hot MSAA mode: 1000=1/px, 0100=4/px, 0010=16/px, 0001=64/px
validTri_in  in  1  triangle/box valid
ready_out  out  1  high when able to accept a triangle
tri_out  out  SIGFIG x VERTS x AXIS  latched triangle
color_out  out  SIGFIG x COLORS  latched colour
sample_out  out  SIGFIG x 2 (signed)  current sample (x,y)
validSamp_out  out  1  sample_out valid this cycle
stall_in  in  1  downstream cannot take the current sample

Behaviour:
- FSM states: IDLE, TEST. Reset (async, any cycle) forces IDLE; all output registers clear to 0; ready_out=1 (ready_out = state==IDLE, combinational).
- Step: step = 1 << (RADIX - k), with k=0,1,2,3 for modes 1000,0100,0010,0001. Step is decoded and latched at accept. A non-one-hot mode decodes as 1000.
- Accept: validTri_in && ready_out at a rising edge.
  - Latch tri, colour, box and step.
  - Set sample = box lower-left.
  - If ur.x < ll.x or ur.y < ll.y (degenerate box): discard the triangle and remain IDLE. No valid sample is produced.
  - Otherwise go to TEST.
- TEST:
  - validSamp_out=1; sample_out, tri_out and color_out are driven from registers.
  - First sample is visible in the cycle after the accept edge (latency 1).
- Advance: in TEST with stall_in=0 at an edge.
  - nx = x + step, computed in SIGFIG+1 bits and compared signed (no wrap).
  - If nx <= ur.x: x = nx.
  - Else: x = ll.x and y = y + step (also SIGFIG+1 bits).
  - Last sample is when nx > ur.x and y + step > ur.y. Advancing past it returns to IDLE: validSamp_out=0, ready_out=1 in the next cycle.
  - The next triangle is accepted no earlier than that IDLE cycle, so there is exactly one bubble between back-to-back triangles.
- Stall: stall_in=1 holds all outputs and state unchanged. No sample is skipped or duplicated. stall_in is ignored in IDLE.
- Box corners not aligned to step: the last column/row is the largest ll + n*step <= ur.
- Sample count per triangle = (floor((ur.x-ll.x)/step)+1) * (floor((ur.y-ll.y)/step)+1).
- validTri_in while in TEST is ignored; upstream must hold it until ready_out.

Optional Feature:
SAMPLE_ITER_PERF_EN
- Defined: adds outputs sampCnt_out (32) and triCnt_out (16), both registers resetting to 0.
  - sampCnt_out increments on each advance edge (TEST && !stall_in).
  - triCnt_out increments on each non-degenerate accept.
  - Both saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. RADIX=10, mode 1000, box (0,0)-(2048,1024), stall_in=0 -> six consecutive valid samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024); ready_out=1 on the 7th cycle after accept.
2. Mode 0100, box (512,512)-(1024,1024) -> four samples (512,512),(1024,512),(512,1024),(1024,1024).
3. Case 1 with stall_in=1 for 3 cycles while (1024,0) is presented -> (1024,0) held 4 cycles, then (2048,0) follows; six unique samples total.
4. Box (2048,0)-(1024,1024) -> validSamp_out never asserts; ready_out stays 1; triCnt_out unchanged (PERF_EN).
5. rst pulsed while the third sample is shown -> validSamp_out=0 and ready_out=1 without waiting for a clock edge; the next triangle starts at its lower-left.
6. validTri_in held high with two 1x1-sample boxes -> first sample valid, one IDLE bubble, second sample valid; sampCnt_out=2, triCnt_out=2.
